uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Byte buffer that sits directly downstream of the 8N1 UART receiver. It captures each byte presented with the receiver's one-cycle `rcv` strobe into a circular FIFO. It exposes the bytes to the consumer (command parser / SoC bus bridge) over a first-word-fall-through valid/ready interface. It also reports fill level, a threshold flag, and sticky overrun status with a saturating drop counter.

Parameters:
AW, 4, address width; FIFO depth = 2**AW entries (default 16)
THRESH, 8, level at or above which `thresh` asserts; legal range 1..2**AW

Ports:
clk  in  1  system clock; all logic rising-edge
rstn  in  1  asynchronous active-low reset
rx_data  in  8  received byte from UART receiver; sampled only when rx_rcv=1
rx_rcv  in  1  one-cycle write strobe from UART receiver
rd_data  out  8  byte at FIFO head; valid only while rd_valid=1
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer accepts head byte when rd_valid&rd_ready at a rising edge
flush  in  1  synchronous clear of FIFO contents
ovr_clr  in  1  synchronous clear of overrun and drop_cnt
level  out  AW+1  number of stored bytes, 0..2**AW
full  out  1  level == 2**AW
thresh  out  1  level >= THRESH
overrun  out  1  sticky: a byte was dropped because FIFO was full
drop_cnt  out  8  saturating count of dropped bytes (stops at 255)

Behaviour:
- Reset (rstn=0, asynchronous, takes effect immediately): write/read pointers=0, level=0, overrun=0, drop_cnt=0. Outputs: rd_valid=0, full=0, thresh=0. rd_data is don't-care. Storage array is not reset.
- Storage: 2**AW x 8 register array. Pointers are AW bits and wrap modulo 2**AW.
- level is a registered AW+1-bit counter. full, rd_valid and thresh are decoded combinationally from level only, with no combinational path from rx_rcv or rd_ready.
- Write: rx_rcv=1 at an edge and (not full, or read in same edge) -> store rx_data at wptr, wptr+1.
- Read: rd_valid&rd_ready at an edge -> rptr+1. rd_data = mem[rptr] (combinational array read, FWFT).
- Latency: a byte written at edge N is on rd_data with rd_valid=1 in the cycle after edge N. An empty FIFO never bypasses rx_data to rd_data.
- Level update per edge: write-only +1; read-only -1; both or neither unchanged.
- Full with simultaneous read and write: both happen, level stays 2**AW, no overrun.
- Empty with simultaneous rx_rcv and rd_ready: no read (rd_valid=0), write accepted, level 0->1.
- Overrun: rx_rcv=1 while full and no read at that edge -> byte discarded, memory and pointers unchanged, overrun<=1, drop_cnt+1 (saturating at 255).
- ovr_clr=1 -> overrun<=0, drop_cnt<=0. If an overrun occurs at the same edge, set wins: overrun=1, drop_cnt=1.
- flush=1 -> pointers and level <=0 at that edge. Priority over write and read in the same cycle (rx_rcv byte discarded, not counted as overrun). overrun and drop_cnt are unaffected by flush.
- rx_rcv is assumed a single-cycle pulse per byte. A multi-cycle high writes once per high cycle, with no edge detection.
- Reset asserted mid-operation discards all contents. The first rx_rcv after deassertion is stored normally.

Test Plan:
- Reset, then write 0x55 at edge N with rd_ready=0 -> rd_valid=1, rd_data=0x55, level=1 from cycle N+1; rd_ready pulse -> rd_valid=0, level=0.
- Write 16 bytes 0x00..0x0F (AW=4) with rd_ready=0 -> full=1, level=16, thresh first asserts when level reaches 8. Drain -> data read back in order 0x00..0x0F, with a wrapped second pass also correct.
- Fill to 16, send 3 more bytes 0xA0..0xA2 -> overrun=1, drop_cnt=3, contents unchanged. Assert ovr_clr coincident with a 4th drop -> overrun=1, drop_cnt=1.
- Full FIFO, rx_rcv=1 with 0x77 and rd_ready=1 at the same edge -> level stays 16, overrun=0, 0x77 read out 16th after drain.
- Level 5, flush=1 together with rx_rcv=1 (0x33) -> next cycle level=0, rd_valid=0, overrun unchanged, 0x33 never appears.
- Write 300 bytes to a full FIFO with no reads -> drop_cnt saturates at 255. rstn pulse low mid-cycle -> level=0, overrun=0, drop_cnt=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Byte buffer placed directly after the 8N1 UART receiver. Each byte presented
// with the receiver's one-cycle rx_rcv strobe is written into a circular FIFO
// of 2**AW entries. The consumer sees the head byte through a
// first-word-fall-through valid/ready interface. Fill level, a threshold flag
// and sticky overrun status with a saturating drop counter are reported.
//
// Ports:
//   clk       in   1     system clock, rising edge
//   rstn      in   1     asynchronous active-low reset
//   rx_data   in   8     received byte, sampled when rx_rcv=1
//   rx_rcv    in   1     one-cycle write strobe
//   rd_data   out  8     byte at FIFO head (valid while rd_valid=1)
//   rd_valid  out  1     FIFO non-empty
//   rd_ready  in   1     consumer accepts head byte on rd_valid&rd_ready
//   flush     in   1     synchronous clear of FIFO contents
//   ovr_clr   in   1     synchronous clear of overrun and drop_cnt
//   level     out  AW+1  number of stored bytes, 0..2**AW
//   full      out  1     level == 2**AW
//   thresh    out  1     level >= THRESH
//   overrun   out  1     sticky: a byte was dropped while full
//   drop_cnt  out  8     saturating count of dropped bytes
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    rx_data,
    input  logic          rx_rcv,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    input  logic          flush,
    input  logic          ovr_clr,
    output logic [AW:0]   level,
    output logic          full,
    output logic          thresh,
    output logic          overrun,
    output logic [7:0]    drop_cnt
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] LV_DEPTH  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LV_THRESH = (AW + 1)'(THRESH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_overrun;
    logic [7:0]    r_drop_cnt;

    logic          w_full;
    logic          w_rd_valid;
    logic          w_rd_fire;
    logic          w_wr_en;
    logic          w_drop;
    logic [AW:0]   w_level_nxt;

    // Flags decode from the registered level only, so nothing on the consumer
    // or receiver side can ripple combinationally into rd_valid/full/thresh.
    assign w_full     = (r_level == LV_DEPTH);
    assign w_rd_valid = (r_level != '0);

    // A read frees a slot at the same edge, so a full FIFO can still accept a
    // write when the consumer is draining it. Flush overrides both.
    assign w_rd_fire = w_rd_valid & rd_ready & ~flush;
    assign w_wr_en   = rx_rcv & (~w_full | w_rd_fire) & ~flush;
    assign w_drop    = rx_rcv & w_full & ~w_rd_fire & ~flush;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else begin
            unique case ({w_wr_en, w_rd_fire})
                2'b10:   w_level_nxt = r_level + 1'b1;
                2'b01:   w_level_nxt = r_level - 1'b1;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents are meaningless until
    // written, and leaving it out keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_en)   r_wptr <= r_wptr + 1'b1;
                if (w_rd_fire) r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // A drop at the same edge as ovr_clr wins: the status restarts at one
    // drop instead of being lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (ovr_clr)                 r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end else if (ovr_clr) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign rd_data  = r_mem[r_rptr];
    assign rd_valid = w_rd_valid;
    assign level    = r_level;
    assign full     = w_full;
    assign thresh   = (r_level >= LV_THRESH);
    assign overrun  = r_overrun;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo (AW=4, THRESH=8). Accepted bytes are
// pushed to a scoreboard queue; the head is compared against rd_data whenever
// the FIFO reports data. A small behavioural model tracks overrun/drop_cnt.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;

    logic          clk;
    logic          rstn;
    logic [7:0]    rx_data;
    logic          rx_rcv;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          flush;
    logic          ovr_clr;
    logic [AW:0]   level;
    logic          full;
    logic          thresh;
    logic          overrun;
    logic [7:0]    drop_cnt;

    uart_rx_fifo #(.AW(AW), .THRESH(THRESH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_data  (rx_data),
        .rx_rcv   (rx_rcv),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .flush    (flush),
        .ovr_clr  (ovr_clr),
        .level    (level),
        .full     (full),
        .thresh   (thresh),
        .overrun  (overrun),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    bit         m_ovr  = 1'b0;
    int         m_drop = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status();
        check("level",    32'(level),    32'(sb.size()));
        check("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
        check("full",     32'(full),     32'(sb.size() == DEPTH));
        check("thresh",   32'(thresh),   32'(sb.size() >= THRESH));
        check("overrun",  32'(overrun),  32'(m_ovr));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive inputs, check head byte, update the model,
    // advance past the edge and check the registered status.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit rd,
                         input bit fl = 1'b0, input bit oc = 1'b0);
        bit was_full;
        bit m_rd;
        rx_rcv   = wr;
        rx_data  = d;
        rd_ready = rd;
        flush    = fl;
        ovr_clr  = oc;
        if (sb.size() != 0) check("rd_data", 32'(rd_data), 32'(sb[0]));
        was_full = (sb.size() == DEPTH);
        m_rd     = rd && (sb.size() != 0) && !fl;
        if (fl) begin
            sb.delete();
        end else begin
            if (m_rd) void'(sb.pop_front());
            if (wr && (!was_full || m_rd)) sb.push_back(d);
        end
        if (wr && !fl && was_full && !m_rd) begin
            m_ovr  = 1'b1;
            m_drop = oc ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
        end else if (oc) begin
            m_ovr  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
        rx_rcv   = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
        check_status();
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rstn     = 1'b0;
        rx_data  = 8'h00;
        rx_rcv   = 1'b0;
        rd_ready = 1'b0;
        flush    = 1'b0;
        ovr_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rstn = 1'b1;

        // Single byte: visible the cycle after the write, then consumed.
        cycle(1'b1, 8'h55, 1'b0);
        check("single_data", 32'(rd_data), 32'h55);
        drain(1);

        // Fill to full, drain in order; repeat to exercise pointer wrap.
        fill(8'h00, DEPTH);
        drain(DEPTH);
        fill(8'h10, DEPTH);
        drain(DEPTH);

        // Overrun: three drops, then a fourth coincident with ovr_clr.
        fill(8'h80, DEPTH);
        fill(8'hA0, 3);
        check("drop3", 32'(drop_cnt), 32'd3);
        cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1);
        check("drop_set_wins", 32'(drop_cnt), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous read and write: no overrun, 0x77 comes last.
        cycle(1'b1, 8'h77, 1'b1);
        drain(DEPTH);

        // Flush at level 5 while a byte arrives: byte is discarded.
        fill(8'h40, 5);
        cycle(1'b1, 8'h33, 1'b0, 1'b1);
        cycle(1'b1, 8'h34, 1'b1);
        drain(1);

        // Empty with rx_rcv and rd_ready together: write only.
        cycle(1'b1, 8'h66, 1'b1);
        drain(1);

        // Saturating drop counter.
        fill(8'hC0, DEPTH);
        fill(8'h00, 300);
        check("drop_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset between edges clears status immediately.
        #2;
        rstn = 1'b0;
        #1;
        check("rst_level",   32'(level),    32'd0);
        check("rst_overrun", 32'(overrun),  32'd0);
        check("rst_drop",    32'(drop_cnt), 32'd0);
        check("rst_valid",   32'(rd_valid), 32'd0);
        sb.delete();
        m_ovr  = 1'b0;
        m_drop = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle(1'b1, 8'h5A, 1'b0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
